// File: rtl/mc_control.sv
// rtl/mc_control.sv - multi-cycle MIPS main control FSM with memory-ready stalls
module mc_control #(
  parameter int ST_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [5:0]      op,
  input  logic            mem_ready,
  output logic            aluop1,
  output logic            aluop0,
  output logic            alusrca,
  output logic [1:0]      alusrcb,
  output logic            iord,
  output logic            memread,
  output logic            memwrite,
  output logic            irwrite,
  output logic            pcwrite,
  output logic            pcwritecond,
  output logic [1:0]      pcsource,
  output logic            regdst,
  output logic            memtoreg,
  output logic            regwrite,
  output logic            instr_done,
  output logic            illegal,
  output logic [ST_W-1:0] state
);

  localparam logic [ST_W-1:0] S_FETCH  = ST_W'(0);
  localparam logic [ST_W-1:0] S_DECODE = ST_W'(1);
  localparam logic [ST_W-1:0] S_MEMADR = ST_W'(2);
  localparam logic [ST_W-1:0] S_MEMRD  = ST_W'(3);
  localparam logic [ST_W-1:0] S_MEMWB  = ST_W'(4);
  localparam logic [ST_W-1:0] S_MEMWR  = ST_W'(5);
  localparam logic [ST_W-1:0] S_REXEC  = ST_W'(6);
  localparam logic [ST_W-1:0] S_RWB    = ST_W'(7);
  localparam logic [ST_W-1:0] S_BEQ    = ST_W'(8);
  localparam logic [ST_W-1:0] S_JUMP   = ST_W'(9);
  localparam logic [ST_W-1:0] S_ADDIEX = ST_W'(10);
  localparam logic [ST_W-1:0] S_ADDIWB = ST_W'(11);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  logic [ST_W-1:0] state_q, state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_REXEC;
          OP_BEQ:       state_d = S_BEQ;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDIEX;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWR:  if (mem_ready) state_d = S_FETCH;
      S_REXEC:  state_d = S_RWB;
      S_ADDIEX: state_d = S_ADDIWB;
      // Writeback/branch/jump states and unused encodings all return to fetch.
      default:  state_d = S_FETCH;
    endcase
  end

  assign state = state_q;

  // Outputs are forced low while reset is held, even though state already reads FETCH.
  always_comb begin
    aluop1      = 1'b0;
    aluop0      = 1'b0;
    alusrca     = 1'b0;
    alusrcb     = 2'b00;
    iord        = 1'b0;
    memread     = 1'b0;
    memwrite    = 1'b0;
    irwrite     = 1'b0;
    pcwrite     = 1'b0;
    pcwritecond = 1'b0;
    pcsource    = 2'b00;
    regdst      = 1'b0;
    memtoreg    = 1'b0;
    regwrite    = 1'b0;
    instr_done  = 1'b0;
    illegal     = 1'b0;
    if (rst_n) begin
      case (state_q)
        S_FETCH: begin
          memread = 1'b1;
          alusrcb = 2'b01;
          irwrite = mem_ready;
          pcwrite = mem_ready;
        end
        S_DECODE: begin
          alusrcb = 2'b11;
          illegal = !(op inside {OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J, OP_ADDI});
        end
        S_MEMADR, S_ADDIEX: begin
          alusrca = 1'b1;
          alusrcb = 2'b10;
        end
        S_MEMRD: begin
          memread = 1'b1;
          iord    = 1'b1;
        end
        S_MEMWB: begin
          regwrite   = 1'b1;
          memtoreg   = 1'b1;
          instr_done = 1'b1;
        end
        S_MEMWR: begin
          memwrite   = 1'b1;
          iord       = 1'b1;
          instr_done = mem_ready;
        end
        S_REXEC: begin
          alusrca = 1'b1;
          aluop1  = 1'b1;
        end
        S_RWB: begin
          regwrite   = 1'b1;
          regdst     = 1'b1;
          instr_done = 1'b1;
        end
        S_BEQ: begin
          alusrca     = 1'b1;
          aluop0      = 1'b1;
          pcwritecond = 1'b1;
          pcsource    = 2'b01;
          instr_done  = 1'b1;
        end
        S_JUMP: begin
          pcwrite    = 1'b1;
          pcsource   = 2'b10;
          instr_done = 1'b1;
        end
        S_ADDIWB: begin
          regwrite   = 1'b1;
          instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mc_control.md
# mc_control

Multi-cycle main control FSM for the MIPS datapath. It sequences instruction fetch, decode, execute, memory and writeback, and drives the ALU operation class (`aluop1`/`aluop0`) into the existing ALU-control decoder. It also drives every datapath mux select and write enable. It stalls on a memory-ready handshake, so one shared instruction/data memory can be used.

## Interface
- `ST_W`, default 4: state register width (12 states used).
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `op` in 6: opcode from the instruction register.
- `mem_ready` in 1: memory completes the current access this cycle.
- `aluop1`, `aluop0` out 1 each: ALU class. 00 add, 01 sub, 10 R-type (funct decode).
- `alusrca` out 1: 0 = PC, 1 = rs register.
- `alusrcb` out 2: 00 rt, 01 constant 4, 10 sign-extended immediate, 11 immediate shifted left 2.
- `iord` out 1: memory address mux. 0 = PC, 1 = ALUOut.
- `memread`, `memwrite` out 1: memory strobes.
- `irwrite` out 1: instruction register load.
- `pcwrite`, `pcwritecond` out 1: PC load, and PC load qualified by zero (external AND/OR).
- `pcsource` out 2: 00 ALU, 01 ALUOut, 10 jump target.
- `regdst`, `memtoreg`, `regwrite` out 1: register file controls.
- `instr_done` out 1: one-cycle pulse in the final cycle of each instruction.
- `illegal` out 1: one-cycle pulse when decode sees an unsupported opcode.
- `state` out `ST_W`: current state, for debug.

## Operation
- States and transitions:
  - FETCH(0) → DECODE(1) when `mem_ready`; otherwise hold.
  - DECODE dispatches on `op`:
    - 100011 (lw) / 101011 (sw) → MEMADR(2)
    - 000000 (R-type) → REXEC(6)
    - 000100 (beq) → BEQ(8)
    - 000010 (j) → JUMP(9)
    - 001000 (addi) → ADDIEX(10)
    - any other opcode → FETCH, with `illegal`=1.
  - MEMADR → MEMRD(3) for lw, MEMWR(5) for sw.
  - MEMRD → MEMWB(4) when `mem_ready`; otherwise hold.
  - MEMWR → FETCH when `mem_ready`; otherwise hold.
  - REXEC → RWB(7). ADDIEX → ADDIWB(11).
  - MEMWB, RWB, BEQ, JUMP and ADDIWB → FETCH.
- Output decode is Moore from `state`, except the enables gated by `mem_ready`. Unlisted outputs are 0.
  - FETCH: `memread`=1, `iord`=0, `alusrca`=0, `alusrcb`=01, aluop=00, `pcsource`=00. `irwrite` = `pcwrite` = `mem_ready`.
  - DECODE: `alusrca`=0, `alusrcb`=11, aluop=00 (branch target precompute).
  - MEMADR and ADDIEX: `alusrca`=1, `alusrcb`=10, aluop=00.
  - MEMRD: `memread`=1, `iord`=1.
  - MEMWB: `regwrite`=1, `memtoreg`=1, `regdst`=0.
  - MEMWR: `memwrite`=1, `iord`=1. Write commits only on the `mem_ready` cycle.
  - REXEC: `alusrca`=1, `alusrcb`=00, aluop=10.
  - RWB: `regwrite`=1, `regdst`=1, `memtoreg`=0.
  - BEQ: `alusrca`=1, `alusrcb`=00, aluop=01, `pcwritecond`=1, `pcsource`=01.
  - JUMP: `pcwrite`=1, `pcsource`=10.
  - ADDIWB: `regwrite`=1, `regdst`=0, `memtoreg`=0.
- `instr_done`=1 in these cycles:
  - MEMWB, RWB, BEQ, JUMP and ADDIWB;
  - MEMWR when `mem_ready`.
- Unused state encodings (12–15) → FETCH next cycle with all enables 0.

## Timing
- Reset (`rst_n`=0, asynchronous): `state`=FETCH immediately. While reset is asserted, all outputs are 0, including `memread`, `pcwrite`, `irwrite`, `instr_done` and `illegal`. Outputs take FETCH values in the first cycle after release.
- Reset mid-instruction aborts it. No write enable may pulse during or after the abort until a new FETCH completes.
- Latency with zero wait states:
  - lw 5 cycles; sw 4; R-type 4; addi 4; beq 3; j 3.
  - Illegal opcode 2 cycles.
- Each wait cycle in FETCH, MEMRD or MEMWR adds exactly one cycle. All outputs stay stable while holding.
- `op` is sampled only in DECODE and MEMADR. Changes to `op` in other states have no effect.
- `mem_ready` is ignored outside FETCH, MEMRD and MEMWR.

## Test plan
- **lw, zero wait:** `mem_ready`=1, `op`=100011.
  - States 0,1,2,3,4,0.
  - `irwrite`/`pcwrite` high in cycle 0 only.
  - `regwrite`&`memtoreg` in cycle 4.
  - `instr_done` in cycle 4.
- **sw with 2 wait states at MEMWR:** `op`=101011.
  - MEMWR held 3 cycles with `memwrite`=1 and `iord`=1.
  - `instr_done` only on the third (ready) cycle.
  - Returns to FETCH.
- **R-type then beq:**
  - R-type: aluop=10 in REXEC; `regdst`=1 and `regwrite`=1 in RWB.
  - beq: aluop=01, `pcwritecond`=1, `pcsource`=01 in BEQ.
  - Total 7 cycles.
- **Fetch stall:** `mem_ready`=0 for 3 cycles in FETCH.
  - `memread`=1 throughout; `irwrite`=`pcwrite`=0.
  - Advances to DECODE on the cycle after `mem_ready` rises.
- **Illegal opcode 111111:**
  - `illegal`=1 for one cycle in DECODE.
  - No `regwrite`, `memwrite` or `pcwrite`.
  - Next state FETCH.
- **Reset mid-MEMRD:** drop `rst_n` between clock edges.
  - `state`=0 and all outputs 0 immediately.
  - After release, FETCH `memread`=1 on the first cycle.
  - No `regwrite` occurs.
